// File: rtl/register_file_sequencer_pkg.sv
// Shared types for the register-file sequencer: micro-op codes, acc_in source
// selects, register-file register map and the illegal-operand predicate.
package register_file_sequencer_pkg;

  localparam logic [7:0] REG_ACC    = 8'd8;
  localparam logic [7:0] REG_STATUS = 8'd13;
  localparam logic [7:0] REG_RSVD0  = 8'd14;
  localparam logic [7:0] REG_RSVD1  = 8'd15;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_GET   = 3'd1,
    OP_PUT   = 3'd2,
    OP_ALU   = 3'd3,
    OP_LDI   = 3'd4,
    OP_LOAD  = 3'd5,
    OP_STORE = 3'd6
  } op_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_IMM  = 2'd2,
    SRC_DMEM = 2'd3
  } acc_src_t;

  // Register operand is passed zero-extended to 8 bits so the check is width-agnostic.
  function automatic logic is_illegal_reg(op_t op, logic [7:0] r);
    logic uses_reg;
    logic put_to_special;
    logic reserved;
    uses_reg       = (op == OP_GET) || (op == OP_PUT) || (op == OP_ALU);
    put_to_special = (op == OP_PUT) && ((r == REG_ACC) || (r == REG_STATUS));
    reserved       = (r == REG_RSVD0) || (r == REG_RSVD1);
    return put_to_special || (uses_reg && reserved);
  endfunction

endpackage

// File: rtl/register_file_sequencer_if.sv
// Decoder handshake, register-file strobes and data-memory handshake bundled
// into one interface; slave is the sequencer, master is the decode/memory side.
interface register_file_sequencer_if
  import register_file_sequencer_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int REG_ADDR_WIDTH = 4
);

  logic                      op_valid;
  logic                      op_ready;
  logic [2:0]                op_code;
  logic [REG_ADDR_WIDTH-1:0] op_reg;
  logic [DATA_W-1:0]         op_imm;

  logic [REG_ADDR_WIDTH-1:0] reg_addr;
  logic                      acc_write_enable;
  logic                      read_get_to_acc;
  logic                      write_put_acc;
  logic                      read_data_output_enable;
  logic                      status_write_enable;
  acc_src_t                  acc_src;
  logic [DATA_W-1:0]         imm_out;

  logic                      dmem_req;
  logic                      dmem_we;
  logic                      dmem_ack;

  logic                      busy;
  logic                      err_illegal;
  logic                      err_timeout;

  modport slave (
    input  op_valid, op_code, op_reg, op_imm, dmem_ack,
    output op_ready, reg_addr, acc_write_enable, read_get_to_acc, write_put_acc,
           read_data_output_enable, status_write_enable, acc_src, imm_out,
           dmem_req, dmem_we, busy, err_illegal, err_timeout
  );

  modport master (
    output op_valid, op_code, op_reg, op_imm, dmem_ack,
    input  op_ready, reg_addr, acc_write_enable, read_get_to_acc, write_put_acc,
           read_data_output_enable, status_write_enable, acc_src, imm_out,
           dmem_req, dmem_we, busy, err_illegal, err_timeout
  );

endinterface

// File: rtl/register_file_sequencer_mem_wait_timer.sv
// Saturating up-counter for the memory wait; flags the final allowed wait cycle
// and the expired count so the sequencer can abort without the counter wrapping.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic last_o,
  output logic expired_o
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != TW'(MEM_TIMEOUT))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o    = (count_q == TW'(MEM_TIMEOUT - 1));
  assign expired_o = (count_q == TW'(MEM_TIMEOUT));

endmodule

// File: rtl/register_file_sequencer.sv
// Sequences one decoded micro-op at a time onto the register-file strobes and
// the acc_in source select, including the load/store handshake with data memory.
module register_file_sequencer
  import register_file_sequencer_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int MEM_TIMEOUT    = 15
) (
  input logic                      clk,
  input logic                      reset,
  register_file_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2
  } seq_state_t;

  seq_state_t                state_q, state_d;
  op_t                       op_q, op_d;
  logic [REG_ADDR_WIDTH-1:0] reg_q, reg_d;
  logic [DATA_W-1:0]         imm_q, imm_d;
  logic                      err_timeout_q, err_timeout_d;

  logic tmr_clear;
  logic tmr_en;
  logic tmr_last;
  logic tmr_expired;
  logic illegal;

  assign illegal = is_illegal_reg(op_q, 8'(reg_q));

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (tmr_clear),
    .en_i      (tmr_en),
    .last_o    (tmr_last),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= OP_NOP;
      reg_q         <= '0;
      imm_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      reg_q         <= reg_d;
      imm_q         <= imm_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    reg_d         = reg_q;
    imm_d         = imm_q;
    err_timeout_d = 1'b0;
    tmr_clear     = 1'b0;
    tmr_en        = 1'b0;

    bus.op_ready                = 1'b0;
    bus.busy                    = (state_q != S_IDLE);
    bus.reg_addr                = '0;
    bus.acc_write_enable        = 1'b0;
    bus.read_get_to_acc         = 1'b0;
    bus.write_put_acc           = 1'b0;
    bus.read_data_output_enable = 1'b0;
    bus.status_write_enable     = 1'b0;
    bus.acc_src                 = SRC_NONE;
    bus.dmem_req                = 1'b0;
    bus.dmem_we                 = 1'b0;
    bus.err_illegal             = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.op_ready = 1'b1;
        if (bus.op_valid) begin
          op_d    = op_t'(bus.op_code);
          reg_d   = bus.op_reg;
          imm_d   = bus.op_imm;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d   = S_IDLE;
        tmr_clear = 1'b1;
        if (illegal) begin
          bus.err_illegal = 1'b1;
        end else begin
          case (op_q)
            OP_GET: begin
              bus.reg_addr         = reg_q;
              bus.read_get_to_acc  = 1'b1;
              bus.acc_write_enable = 1'b1;
            end
            OP_PUT: begin
              bus.reg_addr      = reg_q;
              bus.write_put_acc = 1'b1;
            end
            OP_ALU: begin
              bus.reg_addr                = reg_q;
              bus.read_data_output_enable = 1'b1;
              bus.acc_src                 = SRC_ALU;
              bus.acc_write_enable        = 1'b1;
              bus.status_write_enable     = 1'b1;
            end
            OP_LDI: begin
              bus.acc_src          = SRC_IMM;
              bus.acc_write_enable = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
              state_d = S_MEM;
            end
            default: ;
          endcase
        end
      end

      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (op_q == OP_STORE);
        tmr_en       = 1'b1;
        // Load data is only on acc_in during the ack cycle, so this strobe is ack-driven.
        if (bus.dmem_ack) begin
          if (op_q == OP_LOAD) begin
            bus.acc_src          = SRC_DMEM;
            bus.acc_write_enable = 1'b1;
          end
          state_d = S_IDLE;
        end else if (tmr_last || tmr_expired) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.imm_out     = imm_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_register_file_sequencer.sv
// Directed bench for register_file_sequencer: a transaction-level model predicts
// every output each cycle, and literal checks pin the key scenarios.
module tb_register_file_sequencer;

  localparam int MEM_TIMEOUT = 15;

  localparam logic [2:0] C_NOP   = 3'd0;
  localparam logic [2:0] C_GET   = 3'd1;
  localparam logic [2:0] C_PUT   = 3'd2;
  localparam logic [2:0] C_ALU   = 3'd3;
  localparam logic [2:0] C_LDI   = 3'd4;
  localparam logic [2:0] C_LOAD  = 3'd5;
  localparam logic [2:0] C_STORE = 3'd6;

  typedef struct packed {
    logic       op_ready;
    logic       busy;
    logic [3:0] reg_addr;
    logic       awe;
    logic       rget;
    logic       wput;
    logic       rdoe;
    logic       swe;
    logic [1:0] src;
    logic       req;
    logic       we;
    logic       err_ill;
    logic       err_to;
  } vec_t;

  logic clk;
  logic reset;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int req_cnt, to_cnt, ill_cnt, strobe_cnt;

  register_file_sequencer_if #(.DATA_W(8), .REG_ADDR_WIDTH(4)) bus ();

  register_file_sequencer #(
    .DATA_W         (8),
    .REG_ADDR_WIDTH (4),
    .MEM_TIMEOUT    (MEM_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic vec_t idle_vec();
    vec_t v;
    v          = '0;
    v.op_ready = 1'b1;
    return v;
  endfunction

  function automatic vec_t exec_vec(logic [2:0] op, logic [3:0] r);
    vec_t v;
    logic bad;
    v      = '0;
    v.busy = 1'b1;
    bad = ((op == C_PUT) && (r == 4'd8 || r == 4'd13)) ||
          ((op == C_GET || op == C_PUT || op == C_ALU) && (r >= 4'd14));
    if (bad) begin
      v.err_ill = 1'b1;
    end else begin
      case (op)
        C_GET: begin v.reg_addr = r; v.rget = 1'b1; v.awe = 1'b1; end
        C_PUT: begin v.reg_addr = r; v.wput = 1'b1; end
        C_ALU: begin v.reg_addr = r; v.rdoe = 1'b1; v.src = 2'd1; v.awe = 1'b1; v.swe = 1'b1; end
        C_LDI: begin v.src = 2'd2; v.awe = 1'b1; end
        default: ;
      endcase
    end
    return v;
  endfunction

  // Model: queue of pending per-cycle outputs plus a memory-wait budget.
  vec_t       plan[$];
  int         mem_left  = 0;
  logic       mem_store = 1'b0;
  logic [7:0] model_imm = 8'h00;

  always @(negedge clk) begin
    vec_t e;
    vec_t a;
    vec_t t;
    a = {bus.op_ready, bus.busy, bus.reg_addr, bus.acc_write_enable, bus.read_get_to_acc,
         bus.write_put_acc, bus.read_data_output_enable, bus.status_write_enable,
         bus.acc_src, bus.dmem_req, bus.dmem_we, bus.err_illegal, bus.err_timeout};
    if (reset) begin
      plan.delete();
      mem_left  = 0;
      model_imm = 8'h00;
      e         = idle_vec();
    end else if (plan.size() > 0) begin
      e = plan.pop_front();
    end else if (mem_left > 0) begin
      e      = '0;
      e.busy = 1'b1;
      e.req  = 1'b1;
      e.we   = mem_store;
      if (bus.dmem_ack) begin
        if (!mem_store) begin
          e.awe = 1'b1;
          e.src = 2'd3;
        end
        mem_left = 0;
      end else begin
        mem_left--;
        if (mem_left == 0) begin
          t        = idle_vec();
          t.err_to = 1'b1;
          plan.push_back(t);
        end
      end
    end else begin
      e = idle_vec();
    end

    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle_%0d outputs: got %05h expected %05h", cyc, a, e);
    end
    if (e.src == 2'd2 || reset) begin
      checks++;
      if (bus.imm_out !== model_imm) begin
        errors++;
        $display("FAIL cycle_%0d imm_out: got %02h expected %02h", cyc, bus.imm_out, model_imm);
      end
    end

    if (!reset && e.op_ready && bus.op_valid) begin
      plan.push_back(exec_vec(bus.op_code, bus.op_reg));
      model_imm = bus.op_imm;
      if ((bus.op_code == C_LOAD || bus.op_code == C_STORE) &&
          exec_vec(bus.op_code, bus.op_reg).err_ill == 1'b0) begin
        mem_left  = MEM_TIMEOUT;
        mem_store = (bus.op_code == C_STORE);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] c, input logic [3:0] r,
                      input logic [7:0] i, input logic ack, input logic rst);
    @(posedge clk);
    #1;
    reset        = rst;
    bus.op_valid = v;
    bus.op_code  = c;
    bus.op_reg   = r;
    bus.op_imm   = i;
    bus.dmem_ack = ack;
    @(negedge clk);
    #1;
    req_cnt    += int'(bus.dmem_req);
    to_cnt     += int'(bus.err_timeout);
    ill_cnt    += int'(bus.err_illegal);
    strobe_cnt += int'(bus.acc_write_enable | bus.status_write_enable | bus.write_put_acc);
  endtask

  task automatic clr_cnt();
    req_cnt    = 0;
    to_cnt     = 0;
    ill_cnt    = 0;
    strobe_cnt = 0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.op_valid = 1'b0;
    bus.op_code  = C_NOP;
    bus.op_reg   = 4'd0;
    bus.op_imm   = 8'h00;
    bus.dmem_ack = 1'b0;
    clr_cnt();

    step(0, C_NOP, 0, 0, 0, 1);
    step(1, C_GET, 3, 8'h11, 0, 1);
    chk("reset_op_ready", bus.op_ready, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_imm_out", bus.imm_out, 0);
    chk("reset_acc_src", bus.acc_src, 0);
    chk("reset_dmem_req", bus.dmem_req, 0);
    step(0, C_NOP, 0, 0, 0, 0);

    // GET r3
    step(1, C_GET, 3, 8'h00, 0, 0);
    chk("get_accept_ready", bus.op_ready, 1);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("get_reg_addr", bus.reg_addr, 3);
    chk("get_rget", bus.read_get_to_acc, 1);
    chk("get_awe", bus.acc_write_enable, 1);
    chk("get_src", bus.acc_src, 0);
    chk("get_ready_low", bus.op_ready, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("get_ready_back", bus.op_ready, 1);

    // LDI 0xA5 then PUT r7 with op_valid held
    step(1, C_LDI, 0, 8'hA5, 0, 0);
    step(1, C_PUT, 7, 8'h00, 0, 0);
    chk("ldi_src", bus.acc_src, 2);
    chk("ldi_imm", bus.imm_out, 8'hA5);
    chk("ldi_awe", bus.acc_write_enable, 1);
    step(1, C_PUT, 7, 8'h00, 0, 0);
    chk("put_accept_ready", bus.op_ready, 1);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("put_wput", bus.write_put_acc, 1);
    chk("put_reg_addr", bus.reg_addr, 7);
    chk("put_awe_low", bus.acc_write_enable, 0);

    // ALU r2, then NOP and the unused opcode
    step(1, C_ALU, 2, 8'h00, 0, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("alu_rdoe", bus.read_data_output_enable, 1);
    chk("alu_src", bus.acc_src, 1);
    chk("alu_swe", bus.status_write_enable, 1);
    step(1, C_NOP, 4, 8'h00, 0, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("nop_busy", bus.busy, 1);
    step(1, 3'd7, 1, 8'h00, 0, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    step(0, C_NOP, 0, 0, 1, 0);
    chk("ack_idle_ignored", bus.acc_write_enable, 0);

    // LOAD, ack in third memory cycle
    clr_cnt();
    step(1, C_LOAD, 0, 8'h00, 0, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("load_exec_req", bus.dmem_req, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("load_mem_awe_low", bus.acc_write_enable, 0);
    step(0, C_NOP, 0, 0, 1, 0);
    chk("load_ack_awe", bus.acc_write_enable, 1);
    chk("load_ack_src", bus.acc_src, 3);
    chk("load_we", bus.dmem_we, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("load_req_drop", bus.dmem_req, 0);
    chk("load_busy_drop", bus.busy, 0);
    chk("load_req_cycles", req_cnt, 3);

    // STORE, no ack
    clr_cnt();
    step(1, C_STORE, 0, 8'h00, 0, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("store_we", bus.dmem_we, 1);
    for (int k = 0; k < 20; k++) step(0, C_NOP, 0, 0, 0, 0);
    chk("store_req_cycles", req_cnt, MEM_TIMEOUT);
    chk("store_timeout_pulses", to_cnt, 1);
    chk("store_no_strobes", strobe_cnt, 0);

    // Illegal: PUT r8 and ALU r15
    clr_cnt();
    step(1, C_PUT, 8, 8'h00, 0, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("ill_put_err", bus.err_illegal, 1);
    chk("ill_put_wput", bus.write_put_acc, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("ill_put_idle", bus.op_ready, 1);
    step(1, C_ALU, 15, 8'h00, 0, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("ill_alu_err", bus.err_illegal, 1);
    chk("ill_alu_rdoe", bus.read_data_output_enable, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("ill_pulses", ill_cnt, 2);
    chk("ill_no_strobes", strobe_cnt, 0);

    // Reset in second memory cycle of a LOAD
    step(1, C_LOAD, 0, 8'h00, 0, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("rst_pre_req", bus.dmem_req, 1);
    step(0, C_NOP, 0, 0, 0, 1);
    chk("rst_mid_req", bus.dmem_req, 0);
    chk("rst_mid_awe", bus.acc_write_enable, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("rst_after_ready", bus.op_ready, 1);
    step(1, C_GET, 5, 8'h00, 0, 0);
    step(0, C_NOP, 0, 0, 0, 0);
    chk("rst_get_reg_addr", bus.reg_addr, 5);
    chk("rst_get_rget", bus.read_get_to_acc, 1);
    step(0, C_NOP, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file_sequencer.md
Name: register_file_sequencer

Overview:
- Control sequencer that accepts one decoded micro-op at a time and drives the register-file strobes for it: acc_write_enable, read_get_to_acc, write_put_acc, reg_addr, read_data_output_enable and status_write_enable.
- Also drives the source select for the external acc_in bus and handles load/store handshakes with data memory (address taken by memory from register-file dmar).
- Sits between instruction decode and register_file; it guarantees exactly one driver on acc_in and read_data per cycle.

Parameters:
- DATA_W, 8, datapath / immediate width
- REG_ADDR_WIDTH, 4, register select width
- MEM_TIMEOUT, 15, max cycles to wait for dmem_ack before abort (1..255)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- op_valid  in  1  decoder presents an op
- op_ready  out  1  sequencer accepts op this cycle
- op_code  in  3  op_t: NOP, GET, PUT, ALU, LDI, LOAD, STORE
- op_reg  in  REG_ADDR_WIDTH  register operand
- op_imm  in  DATA_W  immediate, used by LDI
- reg_addr  out  REG_ADDR_WIDTH  to register_file
- acc_write_enable, read_get_to_acc, write_put_acc, read_data_output_enable, status_write_enable  out  1 each  to register_file
- acc_src  out  2  acc_src_t: NONE, ALU, IMM, DMEM; selects external acc_in driver
- imm_out  out  DATA_W  captured immediate, valid when acc_src==IMM
- dmem_req  out  1  memory request, held until ack or timeout
- dmem_we  out  1  1=store (acc to dmem[dmar]), 0=load
- dmem_ack  in  1  memory done; load data valid on acc_in this cycle
- busy  out  1  state != IDLE
- err_illegal  out  1  one-cycle pulse: illegal op aborted
- err_timeout  out  1  one-cycle pulse: memory timeout

Behaviour:
- Reset (async, any state, including mid-memory access): state=IDLE; all strobes, dmem_req, dmem_we, err_* = 0; reg_addr=0; acc_src=NONE; imm_out=0; timer=0. dmem_req drops immediately.
- All outputs are registered or decoded from registered state and captured op; no combinational path from op_* to strobes.
- IDLE: op_ready=1. When op_valid=1, capture op_code, op_reg and op_imm, then go to EXEC. Strobes appear the cycle after acceptance. Throughput is at most 1 op per 2 cycles.
- EXEC (exactly one cycle, op_ready=0):
  - NOP: no strobes.
  - GET: reg_addr=op_reg, read_get_to_acc=1, acc_write_enable=1, acc_src=NONE.
  - PUT: reg_addr=op_reg, write_put_acc=1.
  - ALU: reg_addr=op_reg, read_data_output_enable=1, acc_src=ALU, acc_write_enable=1, status_write_enable=1.
  - LDI: acc_src=IMM, imm_out=op_imm, acc_write_enable=1.
  - LOAD/STORE: go to MEM with timer=0; no strobes.
  - All other ops: return to IDLE.
- Illegal ops: PUT to ACC (8) or STATUS (13); any of GET/PUT/ALU with op_reg 14 or 15. EXEC asserts no strobes and pulses err_illegal, then returns to IDLE.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE, 0 for LOAD; timer increments each cycle.
  - dmem_ack=1: for LOAD, same cycle assert acc_src=DMEM and acc_write_enable=1 (combinational from ack, the only such path). Next state IDLE with dmem_req deasserted.
  - Ack with timer==MEM_TIMEOUT-1 counts as success.
  - Otherwise, when timer reaches MEM_TIMEOUT with no ack: drop dmem_req, pulse err_timeout, go to IDLE; acc unchanged.
  - dmem_ack outside MEM is ignored.
- Bus exclusivity invariants:
  - read_get_to_acc=1 implies acc_src=NONE.
  - acc_write_enable=1 implies exactly one acc_in source is active.
  - At most one of write_put_acc / acc_write_enable is high, except none are high in NOP.
- Timer width is $clog2(MEM_TIMEOUT+1); the timer never wraps.

Decomposition:
- register_file_pkg gains op_t (3-bit enum), acc_src_t (2-bit enum) and the illegal-register predicate function. It reuses the existing REG_* constants.
- seq_state_t (IDLE, EXEC, MEM) stays local to the module.
- One sub-module, mem_wait_timer: load/clear, count enable, expired flag at MEM_TIMEOUT.

Test Plan:
- GET r3 accepted at cycle 0 -> cycle 1: reg_addr=3, read_get_to_acc=1, acc_write_enable=1, acc_src=NONE; op_ready back to 1 at cycle 2.
- LDI 0xA5 then PUT r7 back-to-back (op_valid held) -> LDI strobes imm_out=0xA5 with acc_src=IMM. PUT accepted 2 cycles after LDI, then write_put_acc=1 with reg_addr=7.
- LOAD with dmem_ack on 3rd MEM cycle -> dmem_req high 3 cycles, dmem_we=0. acc_write_enable and acc_src=DMEM only in the ack cycle; next cycle dmem_req=0 and busy=0.
- STORE with no ack, MEM_TIMEOUT=15 -> dmem_req high exactly 15 cycles, err_timeout pulses once, no acc or status strobes.
- PUT reg 8 and ALU reg 15 -> no register-file strobes, err_illegal one-cycle pulse each, sequencer returns to IDLE.
- Reset asserted in the 2nd MEM cycle of a LOAD -> dmem_req and all strobes 0 that cycle. After release, op_ready=1 and a subsequent GET behaves normally.
